switch_debounce: RTL and testbench

Input-side conditioner for the board's push-buttons/switches: synchronizes each raw switch pin into the clock domain, debounces it with a per-channel stability counter, and emits a clean level, one-cycle press/release strobes, and a per-channel LED toggle state. It sits between the top-level switch pins and any logic or LED outputs that need stable, edge-qualified user input. It replaces raw switch-to-LED wiring wherever bounce matters.

---
 rtl/switch_debounce_pkg.sv | 37 +++
 rtl/switch_debounce_if.sv | 22 ++
 rtl/switch_debounce_channel.sv | 78 +++++++
 rtl/switch_debounce.sv | 36 +++
 tb/tb_switch_debounce.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/switch_debounce_pkg.sv
// Shared board constants and per-channel types for the switch conditioner.
package switch_debounce_pkg;

  // Supported board clocks.
  localparam int CLK_HZ_25M = 25_000_000;
  localparam int CLK_HZ_27M = 27_000_000;
  localparam int CLK_HZ_12M = 12_000_000;

  // Active board clock and the settle time a switch must hold before it is believed.
  localparam int CLK_HZ      = CLK_HZ_25M;
  localparam int DEBOUNCE_MS = 10;

  // Milliseconds to clock cycles; divides first so 27 MHz * ms stays in 32 bits.
  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

  localparam int DEBOUNCE_CYCLES     = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int DEBOUNCE_CYCLES_25M = ms_to_cycles(CLK_HZ_25M, DEBOUNCE_MS);
  localparam int DEBOUNCE_CYCLES_27M = ms_to_cycles(CLK_HZ_27M, DEBOUNCE_MS);
  localparam int DEBOUNCE_CYCLES_12M = ms_to_cycles(CLK_HZ_12M, DEBOUNCE_MS);

  // Per-channel debounce state: synchronized input agrees with the stable level or not.
  typedef enum logic {
    ST_MATCH = 1'b0,
    ST_COUNT = 1'b1
  } ch_state_e;

  // Everything one channel reports back to the top.
  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic led;
  } sw_evt_t;

endpackage

// File: rtl/switch_debounce_if.sv
// Switch pins in, conditioned levels/strobes/LED toggles out.
interface switch_debounce_if #(
  parameter int NUM_SW = 4
) ();
  logic [NUM_SW-1:0] i_Switch;
  logic [NUM_SW-1:0] o_Switch;
  logic [NUM_SW-1:0] o_Press;
  logic [NUM_SW-1:0] o_Release;
  logic [NUM_SW-1:0] o_LED;

  // Board side: drives pins, consumes conditioned outputs.
  modport master (
    output i_Switch,
    input  o_Switch, o_Press, o_Release, o_LED
  );

  // Conditioner side.
  modport slave (
    input  i_Switch,
    output o_Switch, o_Press, o_Release, o_LED
  );
endinterface

// File: rtl/switch_debounce_channel.sv
// Single switch channel: 2-flop synchronizer, stability counter, stable level,
// press/release strobes and LED toggle. Every output is a flop.
module switch_debounce_channel
  import switch_debounce_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = 4
) (
  input  logic    i_Clk,
  input  logic    i_Rst,
  input  logic    i_Sw,
  output sw_evt_t o_Evt
);

  localparam int CW = $clog2(DEBOUNCE_LIMIT);
  // Count value on which a still-present mismatch is accepted; always fits in CW bits.
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_LIMIT - 1);

  logic          r_sync1, r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_level, r_press, r_release, r_led;

  ch_state_e     w_state;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_accept;

  // Bring the asynchronous pin into the clock domain.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_Sw;
      r_sync2 <= r_sync1;
    end
  end

  // Implicit state: counting only while the synchronized pin disagrees with the stable level.
  always_comb begin
    w_state = (r_sync2 != r_level) ? ST_COUNT : ST_MATCH;
  end

  // Counter advance/accept; any return to agreement restarts from zero.
  always_comb begin
    w_cnt_nxt = '0;
    w_accept  = 1'b0;
    case (w_state)
      ST_MATCH: w_cnt_nxt = '0;
      ST_COUNT: begin
        if (r_cnt == LAST) w_accept  = 1'b1;
        else               w_cnt_nxt = r_cnt + 1'b1;
      end
      default: w_cnt_nxt = '0;
    endcase
  end

  // Registered outputs: strobes fire on the same edge the stable level flips.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_led     <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_press   <= w_accept &  r_sync2;
      r_release <= w_accept & ~r_sync2;
      if (w_accept)           r_level <= r_sync2;
      if (w_accept & r_sync2) r_led   <= ~r_led;
    end
  end

  assign o_Evt.level = r_level;
  assign o_Evt.press = r_press;
  assign o_Evt.rel   = r_release;
  assign o_Evt.led   = r_led;

endmodule

// File: rtl/switch_debounce.sv
// NUM_SW independent debounced switch channels behind one interface.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int NUM_SW         = 4,
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_CYCLES
) (
  input  logic            i_Clk,
  input  logic            i_Rst,
  switch_debounce_if.slave sw
);

  sw_evt_t [NUM_SW-1:0] w_evt;
  logic    [NUM_SW-1:0] w_level, w_press, w_release, w_led;

  for (genvar g = 0; g < NUM_SW; g++) begin : g_ch
    switch_debounce_channel #(
      .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_ch (
      .i_Clk (i_Clk),
      .i_Rst (i_Rst),
      .i_Sw  (sw.i_Switch[g]),
      .o_Evt (w_evt[g])
    );
    assign w_level[g]   = w_evt[g].level;
    assign w_press[g]   = w_evt[g].press;
    assign w_release[g] = w_evt[g].rel;
    assign w_led[g]     = w_evt[g].led;
  end

  assign sw.o_Switch  = w_level;
  assign sw.o_Press   = w_press;
  assign sw.o_Release = w_release;
  assign sw.o_LED     = w_led;

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with DEBOUNCE_LIMIT=4, NUM_SW=4.
module tb_switch_debounce;
  localparam int NSW = 4;
  localparam int LIM = 4;
  // Edges from the sampling edge to the accepting edge, inclusive.
  localparam int LAT = LIM + 2;

  logic i_Clk = 1'b0;
  logic i_Rst = 1'b1;

  switch_debounce_if #(.NUM_SW(NSW)) u_if ();

  switch_debounce #(
    .NUM_SW        (NSW),
    .DEBOUNCE_LIMIT(LIM)
  ) u_dut (
    .i_Clk (i_Clk),
    .i_Rst (i_Rst),
    .sw    (u_if)
  );

  always #5 i_Clk = ~i_Clk;

  int n_chk = 0;
  int n_err = 0;

  // Strobe / level activity seen mid-cycle (strobes live exactly one cycle).
  int press_cnt [NSW] = '{default: 0};
  int rel_cnt   [NSW] = '{default: 0};
  int both_cnt  = 0;
  int sw2_hi    = 0;

  always @(negedge i_Clk) begin
    for (int n = 0; n < NSW; n++) begin
      if (u_if.o_Press[n])                     press_cnt[n] <= press_cnt[n] + 1;
      if (u_if.o_Release[n])                   rel_cnt[n]   <= rel_cnt[n] + 1;
      if (u_if.o_Press[n] && u_if.o_Release[n]) both_cnt    <= both_cnt + 1;
    end
    if (u_if.o_Switch[2]) sw2_hi <= sw2_hi + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_Clk);
      #1;
    end
  endtask

  function automatic int outs_all();
    return int'({u_if.o_Switch, u_if.o_Press, u_if.o_Release, u_if.o_LED});
  endfunction

  task automatic do_reset();
    u_if.i_Switch = '0;
    i_Rst = 1'b1;
    step(3);
    i_Rst = 1'b0;
    step(2);
  endtask

  int p0, p1, p2, r2;

  initial begin
    u_if.i_Switch = '0;

    // Reset state, then idle with pins low
    step(3);
    chk("reset_outs", outs_all(), 0);
    i_Rst = 1'b0;
    step(50);
    chk("idle_outs", outs_all(), 0);
    chk("idle_press", press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3], 0);
    chk("idle_release", rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3], 0);

    // Clean press / release on ch0
    u_if.i_Switch = 4'b0001;
    for (int i = 1; i <= LAT; i++) begin
      step(1);
      chk($sformatf("press0_e%0d", i), int'(u_if.o_Press), (i == LAT) ? 1 : 0);
    end
    chk("press0_level", int'(u_if.o_Switch), 1);
    chk("press0_led", int'(u_if.o_LED), 1);
    step(1);
    chk("press0_single", int'(u_if.o_Press), 0);
    u_if.i_Switch = 4'b0000;
    for (int i = 1; i <= LAT; i++) begin
      step(1);
      chk($sformatf("rel0_e%0d", i), int'(u_if.o_Release), (i == LAT) ? 1 : 0);
    end
    chk("rel0_level", int'(u_if.o_Switch), 0);
    chk("rel0_led_kept", int'(u_if.o_LED), 1);
    step(1);
    chk("rel0_single", int'(u_if.o_Release), 0);
    chk("ch0_press_total", press_cnt[0], 1);
    chk("ch0_rel_total", rel_cnt[0], 1);

    // Bounce on ch1, then settle high
    do_reset();
    p1 = press_cnt[1];
    for (int j = 0; j < 8; j++) begin
      u_if.i_Switch[1] = (j % 2 == 0);
      step(1);
    end
    u_if.i_Switch[1] = 1'b1;
    for (int i = 1; i <= LAT; i++) begin
      step(1);
      chk($sformatf("bounce1_lvl_e%0d", i), int'(u_if.o_Switch[1]), (i == LAT) ? 1 : 0);
    end
    step(10);
    chk("bounce1_one_press", press_cnt[1] - p1, 1);
    chk("bounce1_led", int'(u_if.o_LED), 4'b0010);

    // Glitch of LIM-1 cycles rejected; LIM cycles just accepted
    do_reset();
    p2 = press_cnt[2];
    r2 = rel_cnt[2];
    u_if.i_Switch[2] = 1'b1;
    step(LIM - 1);
    u_if.i_Switch[2] = 1'b0;
    step(12);
    chk("glitch2_level_never", sw2_hi, 0);
    chk("glitch2_no_press", press_cnt[2] - p2, 0);
    u_if.i_Switch[2] = 1'b1;
    step(LIM);
    u_if.i_Switch[2] = 1'b0;
    step(12);
    chk("edge2_press", press_cnt[2] - p2, 1);
    chk("edge2_release", rel_cnt[2] - r2, 1);
    chk("edge2_level", int'(u_if.o_Switch[2]), 0);

    // Simultaneous presses on ch0/ch3, LED toggles twice
    do_reset();
    u_if.i_Switch = 4'b1001;
    for (int i = 1; i <= LAT; i++) begin
      step(1);
      chk($sformatf("sim_press_e%0d", i), int'(u_if.o_Press), (i == LAT) ? 4'b1001 : 0);
    end
    chk("sim_led1", int'(u_if.o_LED), 4'b1001);
    step(1);
    u_if.i_Switch = 4'b0000;
    for (int i = 1; i <= LAT; i++) begin
      step(1);
      chk($sformatf("sim_rel_e%0d", i), int'(u_if.o_Release), (i == LAT) ? 4'b1001 : 0);
    end
    chk("sim_led_after_rel", int'(u_if.o_LED), 4'b1001);
    step(1);
    u_if.i_Switch = 4'b1001;
    step(LAT);
    chk("sim_press2", int'(u_if.o_Press), 4'b1001);
    chk("sim_led2", int'(u_if.o_LED), 4'b0000);

    // Reset in the middle of a count, pin held high through it
    do_reset();
    p0 = press_cnt[0];
    u_if.i_Switch = 4'b0001;
    step(3);
    i_Rst = 1'b1;
    #1;
    chk("rstmid_async", outs_all(), 0);
    step(2);
    chk("rstmid_held", outs_all(), 0);
    chk("rstmid_no_strobe", press_cnt[0] - p0, 0);
    i_Rst = 1'b0;
    for (int i = 1; i <= LAT; i++) begin
      step(1);
      chk($sformatf("rstmid_press_e%0d", i), int'(u_if.o_Press[0]), (i == LAT) ? 1 : 0);
    end
    chk("rstmid_led", int'(u_if.o_LED), 1);

    step(2);
    chk("never_both_strobes", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
